// File: rtl/weighted_rr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : weighted_rr_bus_arbiter_if
// Brief    : Request/grant and configuration bundle for the weighted
//            round-robin bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface weighted_rr_bus_arbiter_if #(
    parameter int NUM_MASTERS = 8,
    parameter int ID_W        = 3
);
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic                   config_wr;
    logic [3:0]             config_addr;
    logic [7:0]             config_data;

    // Requesters and software side
    modport master (
        output req, config_wr, config_addr, config_data,
        input  grant, grant_valid, grant_id
    );

    // Arbiter side
    modport slave (
        input  req, config_wr, config_addr, config_data,
        output grant, grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/weighted_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : weighted_rr_bus_arbiter
// Brief    : NUM_MASTERS-way bus arbiter, round-robin or fixed priority,
//            with per-master weighted hold time and per-master enable.
// Revision : 1.0 - initial release
// ============================================================================
module weighted_rr_bus_arbiter #(
    parameter int NUM_MASTERS = 8,
    parameter int WEIGHT_W    = 4,
    parameter int ID_W        = 3
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    weighted_rr_bus_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [ID_W:0]     C_NM_EXT = (ID_W+1)'(NUM_MASTERS);
    localparam logic [ID_W-1:0]   C_LAST   = ID_W'(NUM_MASTERS-1);
    localparam logic [WEIGHT_W-1:0] C_ONE  = WEIGHT_W'(1);

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]          grant_id_q, grant_id_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [WEIGHT_W-1:0]      credit_q, credit_d;
    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     mode_q;
    logic [NUM_MASTERS-1:0]   enable_q;
    logic [WEIGHT_W-1:0]      weight_q [NUM_MASTERS];

    logic [NUM_MASTERS-1:0]   elig;
    logic [NUM_MASTERS-1:0]   hold_mask;
    logic [NUM_MASTERS-1:0]   arb_mask;
    logic [ID_W-1:0]          next_ptr;
    logic [ID_W-1:0]          arb_ptr;
    logic [ID_W-1:0]          scan_base;
    logic [ID_W:0]            scan;
    logic [ID_W-1:0]          win;
    logic                     found;
    logic                     do_arb;
    logic [WEIGHT_W-1:0]      hold_w;
    logic [WEIGHT_W-1:0]      win_w;

    // Next-state: holder bookkeeping, then a single arbitration scan whose
    // mask/start point depend on why the arbitration happens.
    always_comb begin
        elig                  = bus.req & enable_q;
        hold_mask             = '0;
        hold_mask[grant_id_q] = 1'b1;
        next_ptr              = (grant_id_q == C_LAST) ? '0 : grant_id_q + 1'b1;
        hold_w                = (weight_q[grant_id_q] == '0) ? C_ONE : weight_q[grant_id_q];

        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        credit_d      = credit_q;
        rr_ptr_d      = rr_ptr_q;
        do_arb        = 1'b0;
        arb_mask      = elig;
        arb_ptr       = rr_ptr_q;

        case (state_q)
            ST_IDLE: do_arb = 1'b1;
            ST_OWN: begin
                if (!elig[grant_id_q]) begin
                    // Holder dropped its request or was disabled
                    do_arb   = 1'b1;
                    rr_ptr_d = next_ptr;
                    arb_ptr  = next_ptr;
                end else if (credit_q > C_ONE) begin
                    credit_d = credit_q - C_ONE;
                end else if ((elig & ~hold_mask) != '0) begin
                    // Credit spent and someone else waits: hand over
                    do_arb   = 1'b1;
                    rr_ptr_d = next_ptr;
                    arb_ptr  = next_ptr;
                    arb_mask = elig & ~hold_mask;
                end else begin
                    // Nobody else wants the bus: keep it without a bubble
                    credit_d = hold_w;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Fixed priority is a scan that always starts at index 0
        scan_base = mode_q ? '0 : arb_ptr;
        found     = 1'b0;
        win       = '0;
        scan      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            scan = {1'b0, scan_base} + (ID_W+1)'(i);
            if (scan >= C_NM_EXT) begin
                scan = scan - C_NM_EXT;
            end
            if (!found && arb_mask[scan[ID_W-1:0]]) begin
                found = 1'b1;
                win   = scan[ID_W-1:0];
            end
        end
        win_w = (weight_q[win] == '0) ? C_ONE : weight_q[win];

        if (do_arb) begin
            if (found) begin
                state_d       = ST_OWN;
                grant_d       = '0;
                grant_d[win]  = 1'b1;
                grant_id_d    = win;
                grant_valid_d = 1'b1;
                credit_d      = win_w;
            end else begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                credit_d      = '0;
            end
        end
    end

    // State, registered outputs and configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            credit_q      <= '0;
            rr_ptr_q      <= '0;
            mode_q        <= 1'b0;
            enable_q      <= '1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                weight_q[i] <= C_ONE;
            end
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            credit_q      <= credit_d;
            rr_ptr_q      <= rr_ptr_d;
            if (bus.config_wr) begin
                if (bus.config_addr == 4'h0) begin
                    mode_q <= bus.config_data[0];
                end
                if (bus.config_addr == 4'h1) begin
                    enable_q <= bus.config_data[NUM_MASTERS-1:0];
                end
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (bus.config_addr == 4'(i + 2)) begin
                        weight_q[i] <= bus.config_data[WEIGHT_W-1:0];
                    end
                end
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_weighted_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_weighted_rr_bus_arbiter
// Brief    : Self-checking bench; expected grants queued with the stimulus
//            and compared one per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weighted_rr_bus_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] exp_q [$];

    weighted_rr_bus_arbiter_if #(.NUM_MASTERS(8), .ID_W(3)) bus ();

    weighted_rr_bus_arbiter #(.NUM_MASTERS(8), .WEIGHT_W(4), .ID_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] onehot_index(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Advance n clocks, comparing each registered grant to the queue head
    task automatic expect_cycles(input int n, input string name);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard empty at cycle %0d", name, k);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d grant: got %h expected %h", name, k, bus.grant, e);
                end
                checks++;
                if (bus.grant_id !== onehot_index(e) || bus.grant_valid !== (|e)) begin
                    errors++;
                    $display("FAIL %s cycle %0d id/valid: got %0d/%b expected %0d/%b",
                             name, k, bus.grant_id, bus.grant_valid, onehot_index(e), |e);
                end
            end
        end
    endtask

    task automatic push_n(input logic [7:0] g, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(g);
    endtask

    task automatic reset_dut();
        reset           = 1'b1;
        bus.req         = '0;
        bus.config_wr   = 1'b0;
        bus.config_addr = '0;
        bus.config_data = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Writes while no request is active, so grant stays idle
    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        bus.config_wr   = 1'b1;
        bus.config_addr = a;
        bus.config_data = d;
        @(posedge clk);
        #1;
        bus.config_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.grant !== 8'h00) begin
            errors++;
            $display("FAIL reset grant: got %h expected 00", bus.grant);
        end
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_id !== 3'd0) begin
            errors++;
            $display("FAIL reset id/valid: got %0d/%b expected 0/0", bus.grant_id, bus.grant_valid);
        end
        reset = 1'b0;
        bus.req = 8'h01;
        push_n(8'h01, 1);
        expect_cycles(1, "single_grant");
        bus.req = 8'h00;
        push_n(8'h00, 1);
        expect_cycles(1, "single_release");
    endtask

    task automatic test_round_robin();
        reset_dut();
        bus.req = 8'hFF;
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h01 << (i % 8));
        expect_cycles(10, "rr_all");
        bus.req = 8'h00;
        push_n(8'h00, 1);
        expect_cycles(1, "rr_drain");
    endtask

    task automatic test_weights();
        reset_dut();
        cfg_write(4'h2, 8'h03);
        cfg_write(4'h3, 8'h00);          // weight 0 behaves as 1
        bus.req = 8'h03;
        for (int r = 0; r < 2; r++) begin
            push_n(8'h01, 3);
            push_n(8'h02, 1);
        end
        expect_cycles(8, "weighted");
        bus.req = 8'h01;
        push_n(8'h01, 8);
        expect_cycles(8, "single_hold");
        bus.req = 8'h00;
        push_n(8'h00, 1);
        expect_cycles(1, "weighted_drain");
    endtask

    task automatic test_fixed_priority();
        reset_dut();
        cfg_write(4'h0, 8'h01);
        cfg_write(4'h4, 8'h0F);          // master 2 may hold 15 cycles
        bus.req = 8'h0C;
        push_n(8'h04, 5);
        expect_cycles(5, "fp_hold");
        bus.req = 8'h08;
        push_n(8'h08, 3);
        expect_cycles(3, "fp_next");
        // From holder 3, round-robin would pick 5; fixed priority picks 1
        bus.req = 8'h2A;
        push_n(8'h02, 1);
        push_n(8'h08, 1);
        push_n(8'h02, 1);
        expect_cycles(3, "fp_lowest");
        bus.req = 8'h00;
        push_n(8'h00, 1);
        expect_cycles(1, "fp_drain");
    endtask

    task automatic test_enable_mask();
        reset_dut();
        cfg_write(4'h2, 8'h0F);
        bus.req = 8'h05;
        push_n(8'h01, 2);
        expect_cycles(2, "en_before");
        // Write lands together with a decision that still sees master 0 enabled
        bus.config_wr   = 1'b1;
        bus.config_addr = 4'h1;
        bus.config_data = 8'hFE;
        push_n(8'h01, 1);
        expect_cycles(1, "en_write_edge");
        bus.config_wr = 1'b0;
        push_n(8'h04, 4);
        expect_cycles(4, "en_forced_release");
        bus.req = 8'h01;
        push_n(8'h00, 4);
        expect_cycles(4, "en_masked");
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        cfg_write(4'h2, 8'h04);
        bus.req = 8'hFF;
        push_n(8'h01, 4);
        push_n(8'h02, 1);
        push_n(8'h04, 1);
        expect_cycles(6, "pre_reset");
        reset = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b expected 00/0", bus.grant, bus.grant_valid);
        end
        #2;
        reset = 1'b0;
        push_n(8'h01, 1);
        push_n(8'h02, 1);
        push_n(8'h04, 1);
        expect_cycles(3, "post_reset");
        bus.req = 8'h00;
        push_n(8'h00, 1);
        expect_cycles(1, "post_reset_drain");
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.req         = '0;
        bus.config_wr   = 1'b0;
        bus.config_addr = '0;
        bus.config_data = '0;
        test_reset();
        test_round_robin();
        test_weights();
        test_fixed_priority();
        test_enable_mask();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
